rib_slave_ram: RTL and testbench
================================

RIB_SLAVE_RAM -- requirements
Module: rib_slave_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning storage size in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request capture and ack (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_i  input  1  access request from the RIB initiator, held high until ack.
REQ-006 SHALL have port we_i  input  1  write flag; 1 = write, 0 = read.
REQ-007 SHALL have port addr_i  input  32  byte address, upper nibble already cleared by the interconnect.
REQ-008 SHALL have port data_i  input  32  write data.
REQ-009 SHALL have port data_o  output  32  read data.
REQ-010 SHALL have port ack_o  output  1  single-cycle completion strobe.

Function
REQ-011 SHALL implement an FSM with states IDLE, WAIT, ACK.
REQ-012 SHALL, in IDLE with req_i=1, capture addr_i, we_i and data_i into holding registers, load a wait counter with LATENCY, and go to WAIT; with LATENCY=0 it SHALL go directly to ACK.
REQ-013 SHALL, in WAIT, decrement the counter each cycle and go to ACK on the cycle the counter reaches 1; the ack therefore occurs LATENCY+1 cycles after capture.
REQ-014 SHALL, in ACK, drive ack_o=1 for exactly one cycle and return to IDLE.
REQ-015 SHALL perform a captured write into the array on the ACK cycle; data_o is unchanged on writes.
REQ-016 SHALL, for a captured read, present the word on data_o in the ACK cycle and hold it until the next read completes.
REQ-017 SHALL form the word index from the captured addr[log2(DEPTH)+1:2] and ignore addr[1:0].
REQ-018 SHALL sample req_i only in IDLE; req_i deasserting during WAIT or ACK SHALL NOT abort the transaction.
REQ-019 SHALL accept a new request in the IDLE cycle immediately after ACK when req_i is still high, giving back-to-back throughput of one access per LATENCY+2 cycles.
REQ-020 SHALL ignore changes to addr_i, we_i and data_i after capture.

Reset
REQ-021 SHALL, while rst=0, force the FSM to IDLE, the counter to 0, ack_o to 0 and data_o to ZeroWord, independent of clk.
REQ-022 SHALL drop an in-flight transaction on reset mid-operation: no write, no ack.
REQ-023 SHALL NOT reset array contents.

Configuration
REQ-024 SHALL support macro RIB_SLAVE_RAM_RANGE_CHK_EN.
REQ-025 SHALL, with RIB_SLAVE_RAM_RANGE_CHK_EN defined, treat any captured address with bits [27:log2(DEPTH)+2] non-zero as out of range: the write is dropped, a read returns ZeroWord, and ack_o is still issued with normal timing.
REQ-026 SHALL, without the macro, ignore those upper bits so that addresses alias (wrap) into the array.

Structure
REQ-027 SHALL take bus widths (MemBus, MemAddrBus), ZeroWord, WriteEnable and RstEnable from the shared defines header; FSM state encodings SHALL stay local.
REQ-028 SHALL place storage in one sub-module, rib_slave_ram_mem: a synchronous single-port array with write enable, index in and data out.

Verification
REQ-029 Write 0x12345678 to 0x10 with LATENCY=2 -> ack_o high exactly 3 cycles after the capture edge, for 1 cycle; a subsequent read of 0x10 returns 0x12345678 in its ack cycle.
REQ-030 Build with LATENCY=0, read 0x0 after writing 0xA5A5A5A5 -> ack in the cycle after capture with data_o=0xA5A5A5A5.
REQ-031 Hold req_i high across 4 back-to-back writes to 0x0, 0x4, 0x8, 0xC with LATENCY=2 -> acks spaced exactly 4 cycles apart; read-back returns all 4 values.
REQ-032 Drop req_i one cycle after capture and change addr_i -> ack still issued at the original time, and the write lands at the captured address.
REQ-033 With DEPTH=256, write 0xDEAD0001 to 0x400 -> without the macro, a read of 0x0 returns 0xDEAD0001; with the macro, the read of 0x0 keeps its old value and a read of 0x400 returns 0x00000000.
REQ-034 Assert rst=0 during WAIT of a write -> ack_o=0 and data_o=0 immediately; the target word is unchanged after reset release.

Source files
------------

// File: rtl/rib_slave_ram_pkg.sv
// Shared bus widths and constants for the RIB slave RAM block.
package rib_slave_ram_pkg;

    localparam int MemBus     = 32;
    localparam int MemAddrBus = 32;

    localparam logic [MemBus-1:0] ZeroWord    = '0;
    localparam logic              WriteEnable = 1'b1;
    localparam logic              RstEnable   = 1'b0;

endpackage

// File: rtl/rib_slave_ram_mem.sv
// Word storage for rib_slave_ram: synchronous write, combinational read of the indexed word.
// The read is registered by the owner, so contents are never reset.
module rib_slave_ram_mem
    import rib_slave_ram_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [MemBus-1:0] wdata,
    output logic [MemBus-1:0] rdata
);

    logic [MemBus-1:0] arr [DEPTH];

    always_ff @(posedge clk) begin
        if (we == WriteEnable) begin
            arr[idx] <= wdata;
        end
    end

    assign rdata = arr[idx];

endmodule

// File: rtl/rib_slave_ram.sv
// RIB slave RAM: captures one request, waits LATENCY cycles, then acks for one cycle.
// Define RIB_SLAVE_RAM_RANGE_CHK_EN to drop out-of-range writes and return zero on out-of-range reads.
module rib_slave_ram
    import rib_slave_ram_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [MemAddrBus-1:0] addr_i,
    input  logic [MemBus-1:0]     data_i,
    output logic [MemBus-1:0]     data_o,
    output logic                  ack_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              cap_we;
    logic              cap_oob;
    logic [AW-1:0]     cap_idx;
    logic [MemBus-1:0] cap_data;
    logic [MemBus-1:0] rd_word;
    logic              mem_we;
    logic              addr_oob;
    logic              unused_addr_bits;

`ifdef RIB_SLAVE_RAM_RANGE_CHK_EN
    assign addr_oob         = |addr_i[27:AW+2];
    assign unused_addr_bits = ^{addr_i[31:28], addr_i[1:0]};
`else
    assign addr_oob         = 1'b0;
    assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};
`endif

    // Holding registers: only loaded on acceptance, later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_i) begin
            cap_we   <= we_i;
            cap_idx  <= addr_i[AW+1:2];
            cap_data <= data_i;
            cap_oob  <= addr_oob;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state  <= IDLE;
            cnt    <= '0;
            ack_o  <= 1'b0;
            data_o <= ZeroWord;
        end else begin
            ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        cnt   <= 4'(LATENCY);
                        state <= (LATENCY == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    ack_o <= 1'b1;
                    if (!cap_we) begin
                        data_o <= cap_oob ? ZeroWord : rd_word;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_we = (state == ACK) && cap_we && !cap_oob;

    rib_slave_ram_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .idx  (cap_idx),
        .wdata(cap_data),
        .rdata(rd_word)
    );

endmodule

// File: tb/tb_rib_slave_ram.sv
// Self-checking bench for rib_slave_ram: directed table, multi-cycle corner sequences and random traffic.
module tb_rib_slave_ram;

    localparam int DEPTH  = 256;
    localparam int LAT    = 2;
    localparam int DEPTH0 = 16;
    localparam int LAT0   = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, ack;
    logic [31:0] addr, wdata, rdata;
    logic        req0, we0, ack0;
    logic [31:0] addr0, wdata0, rdata0;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] last_rd;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        bit          drop;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    rib_slave_ram #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .data_i(wdata), .data_o(rdata), .ack_o(ack)
    );

    rib_slave_ram #(.DEPTH(DEPTH0), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .data_i(wdata0), .data_o(rdata0), .ack_o(ack0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit m_oob(input logic [31:0] a);
`ifdef RIB_SLAVE_RAM_RANGE_CHK_EN
        return ((a & 32'h0FFF_FFFF) >> 2) >= DEPTH;
`else
        return (a == 32'hFFFF_FFFF);
`endif
    endfunction

    // One transaction on the LATENCY=2 instance, checked against the reference array.
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit drop_early, output logic [31:0] got);
        int n;
        req = 1'b1; we = w; addr = a; wdata = d;
        tick;
        if (drop_early) begin
            req = 1'b0; we = ~w; addr = ~a & 32'h0FFF_FFFC; wdata = ~d;
        end
        n = 0;
        do begin
            tick;
            n++;
        end while (!ack && n < 40);
        req = 1'b0;
        got = rdata;
        if (w) begin
            if (!m_oob(a)) model[m_idx(a)] = d;
        end else begin
            last_rd = m_oob(a) ? 32'h0 : model[m_idx(a)];
        end
        chk("ack_latency", 32'(n), 32'(LAT + 1));
        chk("data_o", rdata, last_rd);
        tick;
        chk("ack_width", {31'b0, ack}, 32'h0);
    endtask

    // One transaction on the LATENCY=0 instance; ack must follow capture by one cycle.
    task automatic access0(input bit w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] got);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        tick;
        chk("l0_no_early_ack", {31'b0, ack0}, 32'h0);
        req0 = 1'b0;
        tick;
        chk("l0_ack", {31'b0, ack0}, 32'h1);
        got = rdata0;
        tick;
        chk("l0_ack_width", {31'b0, ack0}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [31:0] vals [4];
        int t, last, acks;

        tbl[0] = '{1'b1, 32'h0000_0000, 32'h1111_0000, 32'h0, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0400, 32'hDEAD_0001, 32'h0, 1'b0};
`ifdef RIB_SLAVE_RAM_RANGE_CHK_EN
        tbl[4] = '{1'b0, 32'h0000_0000, 32'h0, 32'h1111_0000, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_0400, 32'h0, 32'h0000_0000, 1'b0};
`else
        tbl[4] = '{1'b0, 32'h0000_0000, 32'h0, 32'hDEAD_0001, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_0400, 32'h0, 32'hDEAD_0001, 1'b0};
`endif
        tbl[6] = '{1'b1, 32'h0000_0023, 32'hCAFE_F00D, 32'h0, 1'b1};
        tbl[7] = '{1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0};

        rst = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        last_rd = 32'h0;
        tick;
        tick;
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_data", rdata, 32'h0);
        chk("rst_ack0", {31'b0, ack0}, 32'h0);
        chk("rst_data0", rdata0, 32'h0);
        rst = 1'b1;
        tick;

        for (int i = 0; i < DEPTH; i++) begin
            access(1'b1, 32'(i * 4), $urandom, 1'b0, got);
        end

        for (int i = 0; i < 8; i++) begin
            access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].drop, got);
            if (!tbl[i].w) chk($sformatf("tbl_rd%0d", i), got, tbl[i].exp);
        end

        // Back-to-back writes with req held high.
        for (int i = 0; i < 4; i++) vals[i] = $urandom;
        req = 1'b1; we = 1'b1; addr = 32'h0; wdata = vals[0];
        tick;
        t = 0; last = 0; acks = 0;
        while (acks < 4 && t < 100) begin
            tick;
            t++;
            if (ack) begin
                if (acks == 0) chk("b2b_first", 32'(t), 32'(LAT + 1));
                else           chk("b2b_spacing", 32'(t - last), 32'(LAT + 2));
                last = t;
                model[acks] = vals[acks];
                acks++;
                if (acks < 4) begin
                    addr = 32'(acks * 4);
                    wdata = vals[acks];
                end else begin
                    req = 1'b0;
                end
            end
        end
        chk("b2b_count", 32'(acks), 32'd4);
        tick;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 32'(i * 4), 32'h0, 1'b0, got);
            chk("b2b_readback", got, vals[i]);
        end

        // Reset asserted while a write sits in WAIT.
        access(1'b0, 32'h0000_0044, 32'h0, 1'b0, got);
        req = 1'b1; we = 1'b1; addr = 32'h0000_0040; wdata = 32'hBADB_AD00;
        tick;
        tick;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_ack", {31'b0, ack}, 32'h0);
        chk("midrst_data", rdata, 32'h0);
        req = 1'b0;
        tick;
        tick;
        chk("midrst_ack_hold", {31'b0, ack}, 32'h0);
        rst = 1'b1;
        last_rd = 32'h0;
        tick;
        access(1'b0, 32'h0000_0040, 32'h0, 1'b0, got);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = $urandom & 32'h0FFF_FFFF;
            if ($urandom_range(0, 3) != 0) a = a & 32'h0000_03FF;
            access(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 4) == 0), got);
        end

        // LATENCY=0 instance.
        access0(1'b1, 32'h0000_0000, 32'hA5A5_A5A5, got);
        chk("l0_wr_data_hold", got, 32'h0);
        access0(1'b1, 32'h0000_003C, 32'h0F0F_0F0F, got);
        access0(1'b0, 32'h0000_0000, 32'h0, got);
        chk("l0_rd0", got, 32'hA5A5_A5A5);
        access0(1'b0, 32'h0000_003C, 32'h0, got);
        chk("l0_rd3c", got, 32'h0F0F_0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
